if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage front end: owns the program counter, issues word requests to the instruction cache over a ready-based handshake, and presents fetched instruction plus PC+4 to the IF/ID pipeline register. It absorbs variable cache-miss latency, honours hazard-unit stalls, and applies branch/jump redirects, including ones that arrive while a miss is outstanding. It sits between the PC-select logic and the IF/ID register, on the driving side of that register's IF_PC/IF_ir inputs.

## Interface
- pc_size, 18, PC and instruction byte-address width
- data_size, 32, instruction width
- clk  in  1  clock; all state updates on negedge, same edge as the pipeline registers
- rst  in  1  reset, asynchronous, active-high
- hold  in  1  stall from hazard unit, high = freeze (same polarity as IF/ID write-hold)
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  pc_size  target byte address, bits [1:0] = 0
- im_req  out  1  request to instruction cache
- im_addr  out  pc_size  request byte address
- im_ready  in  1  cache returns data this cycle (same cycle as im_req on a hit)
- im_rdata  in  data_size  instruction word, valid while im_ready
- if_pc  out  pc_size  PC+4 of presented instruction
- if_ir  out  data_size  presented instruction, 0 (NOP) when fetch_valid low
- fetch_valid  out  1  if_ir/if_pc carry a real instruction this cycle

## Operation
- Registers: pc (next fetch address), req_addr (address of outstanding request), buf_ir, state.
- States:
  - REQ: im_req=1, im_addr=pc. Ready and no hold/redirect -> present im_rdata, pc<=pc+4. Ready and hold -> buf_ir<=im_rdata, go HOLD, pc unchanged. Not ready -> stay, fetch_valid=0.
  - HOLD: im_req=0; present buf_ir, fetch_valid=1; on edge with hold=0 -> pc<=pc+4, go REQ.
  - DROP: redirect accepted while request pending. im_req=1, im_addr=req_addr (address stable until ready); fetch_valid=0; on im_ready discard data, go REQ.
- Redirect priority: redirect > hold > normal advance.
  - REQ with im_ready=1 or HOLD: pc<=redirect_pc, go REQ, fetched/buffered word discarded.
  - REQ with im_ready=0: req_addr<=pc, pc<=redirect_pc, go DROP.
  - DROP: pc<=redirect_pc (latest wins), stay DROP.
- if_pc = fetched address + 4, mod 2^pc_size (wraps to 0 at top of space).
- Reset (async): pc=0, req_addr=0, buf_ir=0, state=REQ. While rst high: im_req=0, fetch_valid=0, if_ir=0, if_pc=0, im_addr=0. After release: im_req=1, im_addr=0.

## Timing
- Hit: request, data and presentation in one cycle; one instruction per cycle sustained.
- Miss of N cycles: fetch_valid low N cycles, then valid the cycle im_ready rises.
- im_req/im_addr stable from first assertion until the im_ready edge; never withdrawn mid-request.
- Redirect cost: 0 extra cycles when idle/hit, plus remaining miss latency when in DROP.
- hold and im_ready on the same edge: word captured to buf_ir, no loss, no duplicate.
- rst mid-miss: request dropped immediately; cache must tolerate abandoned request.

## Configuration
- IF_FETCH_PERF_EN defined: adds outputs perf_fetches (32 bits, increments per instruction handed off with hold=0) and perf_miss_cycles (32 bits, increments per cycle im_req=1 and im_ready=0); both wrap, cleared by rst.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Shared package: state encoding (REQ, HOLD, DROP), NOP word constant 0, PC increment constant 4.
- One sub-module natural: if_fetch_perf (the two counters), instantiated only under IF_FETCH_PERF_EN.

## Test plan
- Reset, always-hit cache with im_rdata = address: im_addr 0,4,8,...; if_pc 4,8,12; fetch_valid high every cycle after release.
- Miss at address 8 with im_ready delayed 3 cycles: im_addr held 8, fetch_valid low 3 cycles, then if_ir=0x8, if_pc=0xC.
- hold high 2 cycles while word at 0x10 returns: if_ir held 0x10, im_req low, pc advances to 0x14 only after hold drops.
- redirect to 0x100 during miss at 0x20: im_addr stays 0x20 until ready, data discarded (fetch_valid 0), next im_addr 0x100.
- redirect and hold same cycle in HOLD: next im_addr = redirect_pc, buffered word never re-presented.
- With IF_FETCH_PERF_EN: 5 hits + one 3-cycle miss -> perf_fetches=6, perf_miss_cycles=3; rst clears both to 0.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// bus widths, the NOP word and the PC increment.
package if_fetch_unit_pkg;

    localparam int PC_SIZE   = 18;
    localparam int DATA_SIZE = 32;
    localparam int PC_INC    = 4;

    localparam logic [DATA_SIZE-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_HOLD,
        ST_DROP
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-cache request/response bundle; master = fetch unit, slave = cache.
interface if_fetch_unit_if #(
    parameter int pc_size   = if_fetch_unit_pkg::PC_SIZE,
    parameter int data_size = if_fetch_unit_pkg::DATA_SIZE
);

    logic                 im_req;
    logic [pc_size-1:0]   im_addr;
    logic                 im_ready;
    logic [data_size-1:0] im_rdata;

    modport master (output im_req, output im_addr, input im_ready, input im_rdata);
    modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);

endinterface

// File: rtl/if_fetch_perf.sv
// Fetch performance counters: instructions handed to IF/ID and cycles spent
// waiting on the cache. Both wrap; only built when IF_FETCH_PERF_EN is defined.
module if_fetch_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_fire,
    input  logic        miss_cycle,
    output logic [31:0] perf_fetches,
    output logic [31:0] perf_miss_cycles
);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            perf_fetches     <= '0;
            perf_miss_cycles <= '0;
        end else begin
            if (fetch_fire) perf_fetches     <= perf_fetches + 32'd1;
            if (miss_cycle) perf_miss_cycles <= perf_miss_cycles + 32'd1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC ownership, I-cache handshake, stall/redirect
// handling. Optional counters are built with IF_FETCH_PERF_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int pc_size   = PC_SIZE,
    parameter int data_size = DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 redirect,
    input  logic [pc_size-1:0]   redirect_pc,
    if_fetch_unit_if.master      im,
    output logic [pc_size-1:0]   if_pc,
    output logic [data_size-1:0] if_ir,
    output logic                 fetch_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetches,
    output logic [31:0]          perf_miss_cycles
`endif
);

    fetch_state_e         state, state_nxt;
    logic [pc_size-1:0]   pc, pc_nxt;
    logic [pc_size-1:0]   req_addr, req_addr_nxt;
    logic [data_size-1:0] buf_ir, buf_ir_nxt;
    logic [pc_size-1:0]   pc_inc;

    logic                 req_c;
    logic [pc_size-1:0]   addr_c;
    logic [data_size-1:0] ir_c;
    logic                 valid_c;

    // Modular add: the PC wraps to 0 at the top of the address space.
    assign pc_inc = pc + pc_size'(PC_INC);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_REQ;
            pc       <= '0;
            req_addr <= '0;
            buf_ir   <= NOP_WORD;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            buf_ir   <= buf_ir_nxt;
        end
    end

    always_comb begin
        // NOTE: every output takes a default first so no path infers a latch.
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        buf_ir_nxt   = buf_ir;
        req_c        = 1'b0;
        addr_c       = pc;
        ir_c         = NOP_WORD;
        valid_c      = 1'b0;

        unique case (state)
            ST_REQ: begin
                req_c = 1'b1;
                if (im.im_ready) begin
                    if (redirect) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        valid_c = 1'b1;
                        ir_c    = im.im_rdata;
                        if (hold) begin
                            buf_ir_nxt = im.im_rdata;
                            state_nxt  = ST_HOLD;
                        end else begin
                            pc_nxt = pc_inc;
                        end
                    end
                end else if (redirect) begin
                    // Request already on the bus must complete at its original address.
                    req_addr_nxt = pc;
                    pc_nxt       = redirect_pc;
                    state_nxt    = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_REQ;
                end else begin
                    valid_c = 1'b1;
                    ir_c    = buf_ir;
                    if (!hold) begin
                        pc_nxt    = pc_inc;
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_DROP: begin
                req_c  = 1'b1;
                addr_c = req_addr;
                if (redirect)    pc_nxt    = redirect_pc;
                if (im.im_ready) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    // Outputs are forced quiet for the whole time reset is asserted.
    assign im.im_req   = rst ? 1'b0 : req_c;
    assign im.im_addr  = rst ? '0   : addr_c;
    assign if_ir       = rst ? NOP_WORD : ir_c;
    assign if_pc       = rst ? '0   : pc_inc;
    assign fetch_valid = rst ? 1'b0 : valid_c;

`ifdef IF_FETCH_PERF_EN
    if_fetch_perf u_perf (
        .clk              (clk),
        .rst              (rst),
        .fetch_fire       (fetch_valid && !hold),
        .miss_cycle       (im.im_req && !im.im_ready),
        .perf_fetches     (perf_fetches),
        .perf_miss_cycles (perf_miss_cycles)
    );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cache model returns data = address,
// expected hand-offs are queued on stimulus and popped when the DUT hands off.
module tb_if_fetch_unit;

    typedef struct {
        logic [17:0] addr;
        logic [17:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        redirect;
    logic [17:0] redirect_pc;
    logic        ready;
    logic [17:0] if_pc;
    logic [31:0] if_ir;
    logic        fetch_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_miss_cycles;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_addr = '0;
    exp_t        sb[$];

    if_fetch_unit_if bus ();

    assign bus.im_ready = ready;
    assign bus.im_rdata = 32'(bus.im_addr);

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im          (bus),
        .if_pc       (if_pc),
        .if_ir       (if_ir),
        .fetch_valid (fetch_valid)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetches     (perf_fetches),
        .perf_miss_cycles (perf_miss_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every hand-off to IF/ID (valid and not held) must match the queue head.
    always @(posedge clk) begin
        if (!rst && fetch_valid && !hold) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL handoff_unexpected: if_ir=%h if_pc=%h, required no hand-off", if_ir, if_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (if_ir !== 32'(e.addr) || if_pc !== e.pc4) begin
                    errors++;
                    $display("FAIL handoff: if_ir=%h if_pc=%h, required if_ir=%h if_pc=%h",
                             if_ir, if_pc, 32'(e.addr), e.pc4);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] a);
        exp_t e;
        e.addr = a;
        e.pc4  = a + 18'd4;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
        @(posedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, fetch_valid, if_ir, if_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b ir=%h pc=%h, required all 0",
                     bus.im_req, bus.im_addr, fetch_valid, if_ir, if_pc);
        end
        @(negedge clk); #1;
        rst = 1'b0; ready = 1'b0;
        @(posedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, fetch_valid} !== {1'b1, 18'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h valid=%b, required req=1 addr=0 valid=0",
                     bus.im_req, bus.im_addr, fetch_valid);
        end
        tick();
    endtask

    task automatic test_hit(input int n);
        for (int i = 0; i < n; i++) begin
            ready = 1'b1; hold = 1'b0; redirect = 1'b0;
            push(exp_addr);
            @(posedge clk);
            checks++;
            if ({bus.im_req, bus.im_addr, fetch_valid} !== {1'b1, exp_addr, 1'b1}) begin
                errors++;
                $display("FAIL hit: req=%b addr=%h valid=%b, required req=1 addr=%h valid=1",
                         bus.im_req, bus.im_addr, fetch_valid, exp_addr);
            end
            tick();
            exp_addr += 18'd4;
        end
    endtask

    task automatic test_miss(input int n);
        for (int k = 0; k < n; k++) begin
            ready = 1'b0; hold = 1'b0; redirect = 1'b0;
            @(posedge clk);
            checks++;
            if ({bus.im_req, bus.im_addr, fetch_valid, if_ir} !== {1'b1, exp_addr, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL miss_wait: req=%b addr=%h valid=%b ir=%h, required req=1 addr=%h valid=0 ir=0",
                         bus.im_req, bus.im_addr, fetch_valid, if_ir, exp_addr);
            end
            tick();
        end
        ready = 1'b1;
        push(exp_addr);
        @(posedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, fetch_valid} !== {1'b1, exp_addr, 1'b1}) begin
            errors++;
            $display("FAIL miss_return: req=%b addr=%h valid=%b, required req=1 addr=%h valid=1",
                     bus.im_req, bus.im_addr, fetch_valid, exp_addr);
        end
        tick();
        exp_addr += 18'd4;
    endtask

    task automatic test_hold();
        ready = 1'b1; hold = 1'b1;
        push(exp_addr);
        @(posedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, fetch_valid, if_ir} !== {1'b1, exp_addr, 1'b1, 32'(exp_addr)}) begin
            errors++;
            $display("FAIL hold_capture: req=%b addr=%h valid=%b ir=%h, required req=1 addr=%h valid=1 ir=%h",
                     bus.im_req, bus.im_addr, fetch_valid, if_ir, exp_addr, 32'(exp_addr));
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            ready = 1'b0; hold = (c == 0);
            @(posedge clk);
            checks++;
            if ({bus.im_req, fetch_valid, if_ir, if_pc} !== {1'b0, 1'b1, 32'(exp_addr), exp_addr + 18'd4}) begin
                errors++;
                $display("FAIL hold_present: req=%b valid=%b ir=%h pc=%h, required req=0 valid=1 ir=%h pc=%h",
                         bus.im_req, fetch_valid, if_ir, if_pc, 32'(exp_addr), exp_addr + 18'd4);
            end
            tick();
        end
        exp_addr += 18'd4;
    endtask

    task automatic test_redirect_miss();
        logic [17:0] miss_addr;
        miss_addr = exp_addr;
        for (int c = 0; c < 4; c++) begin
            ready       = (c == 3);
            redirect    = (c < 2);
            redirect_pc = (c == 0) ? 18'h80 : 18'h100;
            @(posedge clk);
            checks++;
            if ({bus.im_req, bus.im_addr, fetch_valid, if_ir} !== {1'b1, miss_addr, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL redirect_drop: req=%b addr=%h valid=%b ir=%h, required req=1 addr=%h valid=0 ir=0",
                         bus.im_req, bus.im_addr, fetch_valid, if_ir, miss_addr);
            end
            tick();
        end
        redirect = 1'b0;
        exp_addr = 18'h100;
        test_hit(1);
    endtask

    task automatic test_redirect_hold();
        ready = 1'b1; hold = 1'b1; redirect = 1'b0;
        push(exp_addr);
        @(posedge clk);
        tick();
        ready = 1'b0; redirect = 1'b1; redirect_pc = 18'h300;
        void'(sb.pop_back());
        @(posedge clk);
        checks++;
        if (bus.im_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_hold_req: req=%b, required 0", bus.im_req);
        end
        tick();
        redirect = 1'b0; hold = 1'b0; ready = 1'b1;
        push(18'h300);
        @(posedge clk);
        checks++;
        if ({bus.im_addr, fetch_valid, if_ir} !== {18'h300, 1'b1, 32'h300}) begin
            errors++;
            $display("FAIL redirect_hold_next: addr=%h valid=%b ir=%h, required addr=300 valid=1 ir=300",
                     bus.im_addr, fetch_valid, if_ir);
        end
        tick();
        exp_addr = 18'h304;
    endtask

    task automatic test_redirect_hit(input logic [17:0] target);
        ready = 1'b1; hold = 1'b0; redirect = 1'b1; redirect_pc = target;
        @(posedge clk);
        checks++;
        if ({bus.im_req, bus.im_addr, fetch_valid} !== {1'b1, exp_addr, 1'b0}) begin
            errors++;
            $display("FAIL redirect_hit: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                     bus.im_req, bus.im_addr, fetch_valid, exp_addr);
        end
        tick();
        redirect = 1'b0;
        exp_addr = target;
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf();
        ready = 1'b0; hold = 1'b0; redirect = 1'b0; rst = 1'b1;
        @(posedge clk);
        checks++;
        if ({perf_fetches, perf_miss_cycles} !== 64'h0) begin
            errors++;
            $display("FAIL perf_reset: fetches=%0d miss=%0d, required 0 0", perf_fetches, perf_miss_cycles);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        exp_addr = '0;
        test_hit(5);
        test_miss(3);
        ready = 1'b0;
        @(posedge clk);
        checks++;
        if (perf_fetches !== 32'd6 || perf_miss_cycles !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts: fetches=%0d miss=%0d, required 6 3", perf_fetches, perf_miss_cycles);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_hit(2);
        test_miss(3);
        test_hit(1);
        test_hold();
        test_hit(3);
        test_redirect_miss();
        test_redirect_hold();
        test_redirect_hit(18'h400);
        test_hit(1);
        test_redirect_hit(18'h3FFFC);
        test_hit(2);
        ready = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
`ifdef IF_FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
